// File: rtl/lbr_dump_reader.sv
// Read-side engine for the LBR register file: samples TOS once, then walks the
// FROM/TO ring newest-to-oldest and streams each record out on valid/ready.
module lbr_dump_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int LBR_SIZE   = 16,
    parameter int SKIP_EMPTY = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    output logic [$clog2(LBR_SIZE)+1:0] read_sel,
    input  logic [DATA_WIDTH-1:0]       read_data,
    output logic                        lbr_freeze,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_from,
    output logic [DATA_WIDTH-1:0]       out_to,
    output logic [$clog2(LBR_SIZE)-1:0] out_index,
    output logic                        done,
    output logic [$clog2(LBR_SIZE):0]   count
);

    localparam int L     = $clog2(LBR_SIZE);
    localparam int SEL_W = L + 2;

    localparam logic [SEL_W-1:0] TOS_ADDR = SEL_W'(1 << (L + 1));
    localparam logic [L-1:0]     LAST_K   = L'(LBR_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_TOS,
        RD_FROM,
        RD_TO,
        SEND,
        FIN
    } state_t;

    state_t                state_q, state_n;
    logic [SEL_W-1:0]      sel_q, sel_n;
    logic [L-1:0]          ptr_q, ptr_n;
    logic [L-1:0]          k_q, k_n;
    logic [DATA_WIDTH-1:0] from_q, from_n;
    logic [DATA_WIDTH-1:0] to_q, to_n;
    logic [L:0]            count_q, count_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            k_q     <= '0;
            from_q  <= '0;
            to_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_n;
            sel_q   <= sel_n;
            ptr_q   <= ptr_n;
            k_q     <= k_n;
            from_q  <= from_n;
            to_q    <= to_n;
            count_q <= count_n;
        end
    end

    // read_sel is registered: each transition loads the address the next state
    // reads, so the combinational read_data is valid during that state.
    always_comb begin
        state_n = state_q;
        sel_n   = sel_q;
        ptr_n   = ptr_q;
        k_n     = k_q;
        from_n  = from_q;
        to_n    = to_q;
        count_n = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = RD_TOS;
                    count_n = '0;
                    sel_n   = TOS_ADDR;
                end
            end
            RD_TOS: begin
                ptr_n   = read_data[L-1:0];
                k_n     = '0;
                sel_n   = {2'b00, read_data[L-1:0]};
                state_n = RD_FROM;
            end
            RD_FROM: begin
                from_n  = read_data;
                sel_n   = {2'b01, ptr_q};
                state_n = RD_TO;
            end
            RD_TO: begin
                to_n = read_data;
                if ((SKIP_EMPTY != 0) && (from_q == '0) && (read_data == '0)) begin
                    state_n = FIN;
                end else begin
                    state_n = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    count_n = count_q + (L + 1)'(1);
                    k_n     = k_q + L'(1);
                    ptr_n   = ptr_q - L'(1);
                    if (k_q == LAST_K) begin
                        state_n = FIN;
                    end else begin
                        sel_n   = {2'b00, ptr_q - L'(1)};
                        state_n = RD_FROM;
                    end
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign read_sel   = sel_q;
    assign busy       = (state_q != IDLE);
    assign lbr_freeze = (state_q != IDLE);
    assign out_valid  = (state_q == SEND);
    assign done       = (state_q == FIN);
    assign out_from   = from_q;
    assign out_to     = to_q;
    assign out_index  = ptr_q;
    assign count      = count_q;

endmodule

// File: tb/tb_lbr_dump_reader.sv
// Directed bench for lbr_dump_reader: a small LBR register-file model feeds two
// instances (SKIP_EMPTY=1 and SKIP_EMPTY=0); dumps are compared with fixed tables.
module tb_lbr_dump_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    bit          which = 1'b0;

    logic        start0, start1;
    logic [5:0]  sel0, sel1;
    logic [63:0] rd0, rd1;
    logic        frz0, frz1, busy0, busy1, val0, val1, done0, done1;
    logic [63:0] from0, from1, to0, to1;
    logic [3:0]  idx0, idx1;
    logic [4:0]  cnt0, cnt1;

    logic [63:0] rf_from [16];
    logic [63:0] rf_to   [16];
    logic [63:0] rf_tos;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] rec_from[$];
    logic [63:0] rec_to[$];
    int          rec_idx[$];
    int          rec_cyc[$];
    int          done_cyc, count_at_done, freeze_cycles, freeze_bad, valid_cycles;
    int          sel_trace[1:3];
    bit          aborted;

    always #5 clock = ~clock;

    assign start0 = start & ~which;
    assign start1 = start & which;

    function automatic logic [63:0] rf_read(input logic [5:0] a);
        if (a < 6'd16)       return rf_from[a[3:0]];
        else if (a < 6'd32)  return rf_to[a[3:0]];
        else if (a == 6'd32) return rf_tos;
        return '0;
    endfunction

    always_comb rd0 = rf_read(sel0);
    always_comb rd1 = rf_read(sel1);

    lbr_dump_reader #(.DATA_WIDTH(64), .LBR_SIZE(16), .SKIP_EMPTY(1)) dut (
        .clock(clock), .reset(reset), .start(start0), .read_sel(sel0), .read_data(rd0),
        .lbr_freeze(frz0), .busy(busy0), .out_valid(val0), .out_ready(out_ready),
        .out_from(from0), .out_to(to0), .out_index(idx0), .done(done0), .count(cnt0)
    );

    lbr_dump_reader #(.DATA_WIDTH(64), .LBR_SIZE(16), .SKIP_EMPTY(0)) dut_noskip (
        .clock(clock), .reset(reset), .start(start1), .read_sel(sel1), .read_data(rd1),
        .lbr_freeze(frz1), .busy(busy1), .out_valid(val1), .out_ready(out_ready),
        .out_from(from1), .out_to(to1), .out_index(idx1), .done(done1), .count(cnt1)
    );

    logic        v_valid, v_busy, v_freeze, v_done;
    logic [63:0] v_from, v_to;
    int          v_idx, v_sel, v_count;
    always_comb begin
        v_valid  = which ? val1  : val0;
        v_busy   = which ? busy1 : busy0;
        v_freeze = which ? frz1  : frz0;
        v_done   = which ? done1 : done0;
        v_from   = which ? from1 : from0;
        v_to     = which ? to1   : to0;
        v_idx    = which ? int'(idx1) : int'(idx0);
        v_sel    = which ? int'(sel1) : int'(sel0);
        v_count  = which ? int'(cnt1) : int'(cnt0);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: ready always high; 1: stall the second record 5 cycles;
    // 2: extra start on record 3, reset while record 7 is pending.
    task automatic run_dump(input int mode);
        int          c;
        int          stalls;
        bit          pulsed;
        logic [63:0] s_from, s_to;
        int          s_idx, s_sel;
        rec_from.delete(); rec_to.delete(); rec_idx.delete(); rec_cyc.delete();
        done_cyc = -1; count_at_done = -1; freeze_cycles = 0; freeze_bad = 0;
        valid_cycles = 0; aborted = 0; stalls = 0; pulsed = 0;
        s_from = '0; s_to = '0; s_idx = 0; s_sel = 0;
        @(negedge clock);
        start = 1'b1;
        out_ready = 1'b1;
        c = 0;
        while (c < 200) begin
            @(negedge clock);
            c++;
            start = 1'b0;
            out_ready = 1'b1;
            if (c <= 3) sel_trace[c] = v_sel;
            if (v_busy) begin
                freeze_cycles++;
                if (!v_freeze) freeze_bad++;
            end else if (v_freeze) begin
                freeze_bad++;
            end
            if (v_valid) valid_cycles++;
            if (v_done) begin
                done_cyc = c;
                count_at_done = v_count;
                break;
            end
            if (mode == 1 && v_valid && rec_idx.size() == 1) begin
                if (stalls == 0) begin
                    s_from = v_from; s_to = v_to; s_idx = v_idx; s_sel = v_sel;
                end else begin
                    check_val("bp_valid", 64'(v_valid), 64'd1);
                    check_val("bp_from", v_from, s_from);
                    check_val("bp_to", v_to, s_to);
                    check_val("bp_index", 64'(v_idx), 64'(s_idx));
                    check_val("bp_read_sel", 64'(v_sel), 64'(s_sel));
                end
                if (stalls < 5) begin
                    out_ready = 1'b0;
                    stalls++;
                end
            end
            if (mode == 2 && v_valid && rec_idx.size() == 2 && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            if (mode == 2 && v_valid && rec_idx.size() == 6) begin
                reset = 1'b1;
                out_ready = 1'b0;
                @(negedge clock);
                reset = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (v_valid && out_ready) begin
                rec_from.push_back(v_from);
                rec_to.push_back(v_to);
                rec_idx.push_back(v_idx);
                rec_cyc.push_back(c);
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_idle_after(input string tag);
        @(negedge clock);
        check_val({tag, "_busy_after"}, 64'(v_busy), 64'd0);
        check_val({tag, "_freeze_after"}, 64'(v_freeze), 64'd0);
        check_val({tag, "_done_after"}, 64'(v_done), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_idx;

        for (int i = 0; i < 16; i++) begin
            rf_from[i] = '0;
            rf_to[i]   = '0;
        end
        rf_tos = 64'h0000_dead_0000_00ff;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_val("rst_busy", 64'(busy0), 64'd0);
        check_val("rst_freeze", 64'(frz0), 64'd0);
        check_val("rst_valid", 64'(val0), 64'd0);
        check_val("rst_done", 64'(done0), 64'd0);
        check_val("rst_count", 64'(cnt0), 64'd0);
        check_val("rst_read_sel", 64'(sel0), 64'd0);
        check_val("rst_index", 64'(idx0), 64'd0);
        check_val("rst_from", from0, 64'd0);

        // Empty file: TOS=15 (upper bits ignored), newest slot empty.
        run_dump(0);
        check_val("empty_sel_c1", 64'(sel_trace[1]), 64'd32);
        check_val("empty_sel_c2", 64'(sel_trace[2]), 64'd15);
        check_val("empty_sel_c3", 64'(sel_trace[3]), 64'd31);
        check_val("empty_valid_cycles", 64'(valid_cycles), 64'd0);
        check_val("empty_done_cyc", 64'(done_cyc), 64'd4);
        check_val("empty_count", 64'(count_at_done), 64'd0);
        check_idle_after("empty");

        // Three live entries below TOS=2, walk stops at empty slot 15.
        for (int i = 0; i < 3; i++) begin
            rf_from[i] = 64'h100 + 64'(i);
            rf_to[i]   = 64'h200 + 64'(i);
        end
        rf_tos = 64'd2;
        run_dump(0);
        check_val("three_nrec", 64'(rec_idx.size()), 64'd3);
        for (int n = 0; n < 3 && n < rec_idx.size(); n++) begin
            check_val("three_idx", 64'(rec_idx[n]), 64'(2 - n));
            check_val("three_from", rec_from[n], 64'h102 - 64'(n));
            check_val("three_to", rec_to[n], 64'h202 - 64'(n));
        end
        if (rec_cyc.size() > 0) check_val("three_first_cyc", 64'(rec_cyc[0]), 64'd4);
        check_val("three_done_cyc", 64'(done_cyc), 64'd13);
        check_val("three_count", 64'(count_at_done), 64'd3);
        // start coincident with the done cycle must be ignored
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_val("start_on_done_busy", 64'(busy0), 64'd0);
        @(negedge clock);
        check_val("start_on_done_busy2", 64'(busy0), 64'd0);

        // Full ring, TOS=5, ready held high.
        for (int i = 0; i < 16; i++) begin
            rf_from[i] = 64'hF000 + 64'(i);
            rf_to[i]   = 64'hE000 + 64'(i);
        end
        rf_tos = 64'd5;
        run_dump(0);
        check_val("full_nrec", 64'(rec_idx.size()), 64'd16);
        for (int n = 0; n < 16 && n < rec_idx.size(); n++) begin
            exp_idx = (5 - n) & 15;
            check_val("full_idx", 64'(rec_idx[n]), 64'(exp_idx));
            check_val("full_from", rec_from[n], 64'hF000 + 64'(exp_idx));
            check_val("full_to", rec_to[n], 64'hE000 + 64'(exp_idx));
        end
        if (rec_cyc.size() == 16) check_val("full_last_cyc", 64'(rec_cyc[15]), 64'd49);
        check_val("full_done_cyc", 64'(done_cyc), 64'd50);
        check_val("full_count", 64'(count_at_done), 64'd16);
        check_val("full_freeze_cycles", 64'(freeze_cycles), 64'd50);
        check_val("full_freeze_bad", 64'(freeze_bad), 64'd0);
        check_idle_after("full");

        // Backpressure on the second record.
        run_dump(1);
        check_val("bp_nrec", 64'(rec_idx.size()), 64'd16);
        for (int n = 0; n < 16 && n < rec_idx.size(); n++) begin
            check_val("bp_seq_idx", 64'(rec_idx[n]), 64'((5 - n) & 15));
        end
        if (rec_cyc.size() > 1) check_val("bp_rec2_cyc", 64'(rec_cyc[1]), 64'd12);
        check_val("bp_done_cyc", 64'(done_cyc), 64'd55);
        check_val("bp_count", 64'(count_at_done), 64'd16);
        check_idle_after("bp");

        // Extra start mid-dump, then reset with record 7 pending.
        run_dump(2);
        check_val("rr_aborted", 64'(aborted), 64'd1);
        check_val("rr_nrec", 64'(rec_idx.size()), 64'd6);
        if (rec_idx.size() == 6) begin
            check_val("rr_idx5", 64'(rec_idx[5]), 64'd0);
            check_val("rr_cyc5", 64'(rec_cyc[5]), 64'd19);
        end
        check_val("rr_busy", 64'(busy0), 64'd0);
        check_val("rr_valid", 64'(val0), 64'd0);
        check_val("rr_freeze", 64'(frz0), 64'd0);
        check_val("rr_count", 64'(cnt0), 64'd0);
        rf_tos = 64'd9;
        run_dump(0);
        check_val("rr2_nrec", 64'(rec_idx.size()), 64'd16);
        if (rec_idx.size() == 16) begin
            check_val("rr2_first_idx", 64'(rec_idx[0]), 64'd9);
            check_val("rr2_last_idx", 64'(rec_idx[15]), 64'd10);
        end
        check_val("rr2_done_cyc", 64'(done_cyc), 64'd50);
        check_idle_after("rr2");

        // No-skip instance on an all-zero file, TOS=15.
        for (int i = 0; i < 16; i++) begin
            rf_from[i] = '0;
            rf_to[i]   = '0;
        end
        rf_tos = 64'd15;
        which = 1'b1;
        run_dump(0);
        check_val("noskip_nrec", 64'(rec_idx.size()), 64'd16);
        for (int n = 0; n < 16 && n < rec_idx.size(); n++) begin
            check_val("noskip_idx", 64'(rec_idx[n]), 64'(15 - n));
            check_val("noskip_from", rec_from[n], 64'd0);
        end
        check_val("noskip_done_cyc", 64'(done_cyc), 64'd50);
        check_val("noskip_count", 64'(count_at_done), 64'd16);
        check_idle_after("noskip");
        which = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lbr_dump_reader.md
Name: lbr_dump_reader

Overview:
- Read-side engine for the last-branch-record register file.
- On a start pulse it samples the top-of-stack (TOS) pointer, then walks the FROM/TO ring from newest to oldest entry through the file's single combinational read port.
- Each record is emitted on a valid/ready stream toward the debug/trace export path.
- It asserts a freeze signal while dumping, so the LBR top suppresses writes and the snapshot stays consistent.

Parameters:
- DATA_WIDTH, 64, width of each FROM/TO/TOS register.
- LBR_SIZE, 16, number of ring entries; must be a power of 2.
- SKIP_EMPTY, 1, 1 = stop the walk at the first entry with FROM==0 and TO==0; 0 = always emit LBR_SIZE records.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle dump request; ignored while busy.
- read_sel  output  $clog2(LBR_SIZE)+2  register file read address.
- read_data  input  DATA_WIDTH  register file read data; combinational, valid in the same cycle as read_sel.
- lbr_freeze  output  1  high while busy; LBR top gates all wEn while high.
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  record available.
- out_ready  input  1  consumer accepts the record.
- out_from  output  DATA_WIDTH  branch source address.
- out_to  output  DATA_WIDTH  branch target address.
- out_index  output  $clog2(LBR_SIZE)  ring slot of the current record.
- done  output  1  one-cycle pulse at end of dump.
- count  output  $clog2(LBR_SIZE)+1  records emitted in the current/last dump; holds until next start.

Behaviour:
- Address map, with L = $clog2(LBR_SIZE):
  - FROM[i] at address i.
  - TO[i] at address (1<<L)+i.
  - TOS at address 1<<(L+1); TOS value is read_data[L-1:0].
- Reset values: state IDLE; read_sel, lbr_freeze, busy, out_valid, out_from, out_to, out_index, done, count all 0.
- States:
  - IDLE: on start, go to RD_TOS and clear count.
  - RD_TOS: read_sel = TOS address; latch ptr = TOS, k = 0; go to RD_FROM.
  - RD_FROM: read_sel = ptr; latch from_q; go to RD_TO.
  - RD_TO: read_sel = (1<<L)+ptr; latch to_q.
    - If SKIP_EMPTY and from_q==0 and read_data==0, go to FIN.
    - Otherwise go to SEND.
  - SEND: out_valid = 1 with out_from/out_to/out_index = from_q/to_q/ptr.
    - On out_ready: count++, k++, ptr = ptr-1 mod LBR_SIZE (wrap from 0 to LBR_SIZE-1).
    - Then go to FIN if k was LBR_SIZE-1, else go to RD_FROM.
  - FIN: done = 1 for one cycle; go to IDLE.
- Timing, with start sampled at edge 0:
  - RD_TOS occupies cycle 1.
  - First out_valid in cycle 4.
  - Records are spaced 3 cycles apart with out_ready held high.
  - Full 16-entry dump: last record in cycle 49, done in cycle 50, busy low in cycle 51.
- Stream rules:
  - out_from, out_to, out_index and read_sel are stable while out_valid && !out_ready.
  - out_valid never drops without a handshake, except on reset.
  - Exactly one record is transferred per valid&&ready cycle.
- lbr_freeze equals busy, registered from the state: high from cycle 1 through the FIN cycle.
- read_sel in IDLE and FIN holds its last value; don't-care for the file.
- start while busy: ignored, no restart, no error.
- A start coincident with the done cycle is ignored; the next start in IDLE is accepted.
- Reset mid-dump: next cycle is IDLE with all outputs at reset values (freeze released). A subsequent start begins a fresh dump from the TOS.
- TOS is read exactly once per dump; the walk never re-samples it.
- Zero records emitted (empty newest entry) is legal: count = 0, done still pulses, out_valid never asserts.

Test Plan:
- Empty file after LBR reset (TOS=15, all entries 0), SKIP_EMPTY=1, start → reads addr 32, 15, 31. out_valid never high; done in cycle 4; count=0.
- TOS=2, entries 0..2 = (FROM 0x100+i, TO 0x200+i), rest 0 → three records emitted in order:
  - idx 2 (0x102/0x202)
  - idx 1 (0x101/0x201)
  - idx 0 (0x100/0x200)
  - Then slot 15 is empty, so the walk stops: done, count=3.
- All 16 slots nonzero, TOS=5, out_ready=1 → out_index sequence 5,4,3,2,1,0,15,…,6; done in cycle 50; count=16; lbr_freeze high cycles 1–50.
- Backpressure: out_ready low for 5 cycles on the second record → out_valid, out_from, out_to, out_index and read_sel are unchanged across those cycles. The record is accepted once on release, with no duplicate and no skip.
- Start pulsed again during the dump at record 3 → sequence unaffected. Reset asserted while the 7th record is pending → next cycle busy=0, out_valid=0, lbr_freeze=0. A new start re-reads TOS and restarts from the newest entry.
- SKIP_EMPTY=0, entries all zero, TOS=15 → 16 zero records at indices 15..0; count=16; done pulses.
